io_irq_ctrl: RTL and testbench
==============================

IO_IRQ_CTRL -- requirements
Module: io_irq_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, ready-low cycles per access (legal 0..3).
REQ-002 SHALL have parameter TIMER_RELOAD, default 16'hFFFF, reset value of timer reload latch.
REQ-003 clk  input  1  single system clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  chip select, decoded by the bus from the CPU address.
REQ-006 addr  input  4  register offset, CPU address bits [3:0].
REQ-007 write  input  1  CPU write strobe.
REQ-008 phase3  input  1  CPU commit phase; writes commit only when it is high.
REQ-009 data_i  input  8  CPU write data.
REQ-010 data_o  output  8  registered read data, routed by the bus mux.
REQ-011 ready  output  1  bus ready contribution; the bus ANDs it into the CPU ready.
REQ-012 irq  output  1  level interrupt request to the CPU.
REQ-013 nmi  output  1  level NMI request to the CPU.

Function
REQ-014 Register map SHALL be: 0 FORCE (bit0 irq, bit1 nmi); 1 TLO; 2 THI; 3 CTRL (bit0 run, bit1 autoreload, bit2 irq_en); 4 STATUS (bit0 expired). Offsets 5..15 SHALL read 0 and ignore writes.
REQ-015 A write SHALL commit on the posedge where cs & write & ready & phase3 are all high; there is no other commit path.
REQ-016 data_o SHALL be updated on every posedge where cs is high and write is low, so read latency is 1 cycle; otherwise it holds its value.
REQ-017 Reads of 1/2 SHALL return the live counter low/high byte; reads of 0/3/4 SHALL return the register, with unused bits reading 0.
REQ-018 A TLO write SHALL update only the low byte of the reload latch.
REQ-019 A THI write SHALL update the high byte of the reload latch and load the counter with {data_i, latch_lo} in the same cycle.
REQ-020 Wait FSM states SHALL be IDLE, WAIT, DONE.
REQ-021 Wait FSM, IDLE: on cs with WAIT_STATES>0, go to WAIT with a counter of WAIT_STATES; ready SHALL be low in that same cycle (combinational from cs).
REQ-022 Wait FSM, WAIT: ready low; decrement each clk; go to DONE when the counter reaches 1.
REQ-023 Wait FSM, DONE: ready high; go to IDLE after a posedge with phase3 & cs, or when cs drops.
REQ-024 With WAIT_STATES=0, ready SHALL be constant 1.
REQ-025 ready SHALL be 1 whenever cs is low.
REQ-026 Timer SHALL be a 16-bit down counter, decremented each clk while run=1.
REQ-027 When the timer decrements from 1 to 0, expired SHALL be set.
REQ-028 At expiry with autoreload=1, the next cycle SHALL load the reload latch; with autoreload=0, run SHALL clear and the counter SHALL hold 0.
REQ-029 run=1 with counter 0 SHALL reload without setting expired.
REQ-030 Writing STATUS with bit0=1 SHALL clear expired; writing 0 SHALL have no effect.
REQ-031 When an expiry and a STATUS clear occur in the same cycle, the expiry SHALL win (expired stays 1).
REQ-032 When a THI load and a decrement occur in the same cycle, the load SHALL win.
REQ-033 irq SHALL equal FORCE.bit0 | (expired & irq_en), registered.
REQ-034 nmi SHALL equal FORCE.bit1, registered.

Reset
REQ-035 Reset SHALL clear FORCE, CTRL, STATUS, data_o, irq and nmi, and return the FSM to IDLE.
REQ-036 Reset SHALL set ready to 1, the counter to 0 and the reload latch to TIMER_RELOAD.
REQ-037 Reset asserted mid-access SHALL abort the access with no write committed.
REQ-038 Reset asserted mid-count SHALL stop the timer.

Structure
REQ-039 Package io_irq_pkg SHALL hold register offsets, CTRL/STATUS bit indices and the FSM state encoding.
REQ-040 The timer and reload latch SHALL be sub-module io_irq_timer; the decode, FSM and IRQ logic stay in the top level.

Verification
REQ-041 Write FORCE=8'h03 with phase3=1 -> irq=1 and nmi=1 one cycle later; write 8'h00 -> both 0.
REQ-042 WAIT_STATES=2, read offset 3 -> ready low for exactly 2 cycles, then high; data_o=CTRL the cycle after cs.
REQ-043 Write TLO=8'h03 then THI=8'h00, then CTRL=8'h05 -> expired=1 and irq=1 after 3 clks; run=0; counter reads 0.
REQ-044 CTRL=8'h07 with reload 3 -> expired every 4 clks; STATUS write 8'h01 on the expiry cycle -> expired stays 1.
REQ-045 write=1 with phase3=0 -> no register change; reset pulsed mid-WAIT -> ready=1, FORCE=0, reload latch=16'hFFFF.

Source files
------------

// File: rtl/io_irq_pkg.sv
// ----------------------------------------------------------------------------
// io_irq_pkg
// Shared definitions for the IO/IRQ controller: register offsets, CTRL/STATUS/
// FORCE bit positions and the bus wait-state FSM encoding.
// ----------------------------------------------------------------------------
package io_irq_pkg;

  // Register offsets (CPU address bits [3:0])
  localparam logic [3:0] ADDR_FORCE  = 4'd0;
  localparam logic [3:0] ADDR_TLO    = 4'd1;
  localparam logic [3:0] ADDR_THI    = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd4;

  // FORCE bits
  localparam int FORCE_IRQ = 0;
  localparam int FORCE_NMI = 1;

  // CTRL bits
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IEN  = 2;

  // STATUS bits
  localparam int STATUS_EXP = 0;

  // Bus wait-state FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } wait_state_t;

endpackage

// File: rtl/io_irq_timer.sv
// ----------------------------------------------------------------------------
// io_irq_timer
// 16-bit down counter with a byte-writable reload latch.
//
// Ports
//   clk        system clock, all state on posedge
//   reset      asynchronous active-high reset (counter 0, latch TIMER_RELOAD)
//   i_run      counting enable (CTRL.run)
//   i_lo_we    committed write to TLO: update latch low byte
//   i_hi_we    committed write to THI: update latch high byte and load counter
//   i_wdata    CPU write data
//   o_count    live counter value
//   o_expire   single-cycle strobe: the counter steps 1 -> 0 on this edge
// ----------------------------------------------------------------------------
module io_irq_timer
  import io_irq_pkg::*;
#(
  parameter logic [15:0] TIMER_RELOAD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run,
  input  logic        i_lo_we,
  input  logic        i_hi_we,
  input  logic [7:0]  i_wdata,
  output logic [15:0] o_count,
  output logic        o_expire
);

  logic [15:0] r_count;
  logic [15:0] r_latch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 16'd0;
      r_latch <= TIMER_RELOAD;
    end else begin
      if (i_lo_we) begin
        r_latch[7:0] <= i_wdata;
      end
      // A THI load takes priority over any counting activity this cycle.
      if (i_hi_we) begin
        r_latch[15:8] <= i_wdata;
        r_count       <= {i_wdata, r_latch[7:0]};
      end else if (i_run) begin
        // Running from zero (after an auto-reload expiry, or when started at
        // zero) reloads quietly; only the 1 -> 0 step counts as an expiry.
        if (r_count == 16'd0) begin
          r_count <= r_latch;
        end else begin
          r_count <= r_count - 16'd1;
        end
      end
    end
  end

  // Suppressed by a THI load, since the load replaces the decrement.
  assign o_expire = i_run & ~i_hi_we & (r_count == 16'd1);
  assign o_count  = r_count;

endmodule

// File: rtl/io_irq_ctrl.sv
// ----------------------------------------------------------------------------
// io_irq_ctrl
// CPU-mapped interrupt controller with a programmable down-counting timer and
// a configurable number of bus wait states.
//
// Register map (addr[3:0])
//   0 FORCE  bit0 force irq, bit1 force nmi
//   1 TLO    write: reload latch low byte;  read: live counter low byte
//   2 THI    write: reload latch high byte + counter load; read: counter high
//   3 CTRL   bit0 run, bit1 autoreload, bit2 irq enable
//   4 STATUS bit0 expired (write 1 to clear)
//   5..15    read 0, writes ignored
//
// Ports
//   clk     system clock
//   reset   asynchronous active-high reset
//   cs      chip select from the bus decoder
//   addr    register offset
//   write   CPU write strobe
//   phase3  CPU commit phase, writes only commit while high
//   data_i  CPU write data
//   data_o  registered read data (1-cycle latency)
//   ready   bus ready contribution (low while wait states are inserted)
//   irq     registered level interrupt request
//   nmi     registered level NMI request
// ----------------------------------------------------------------------------
module io_irq_ctrl
  import io_irq_pkg::*;
#(
  parameter int          WAIT_STATES  = 0,
  parameter logic [15:0] TIMER_RELOAD = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [3:0] addr,
  input  logic       write,
  input  logic       phase3,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       ready,
  output logic       irq,
  output logic       nmi
);

  localparam logic [1:0] LP_WS      = 2'(WAIT_STATES);
  localparam logic       LP_NO_WAIT = (WAIT_STATES == 0);

  wait_state_t r_state;
  logic [1:0]  r_wcnt;

  logic [1:0]  r_force;
  logic [2:0]  r_ctrl;
  logic        r_expired;
  logic [7:0]  r_data_o;
  logic        r_irq;
  logic        r_nmi;

  logic        w_commit;
  logic        w_read;
  logic        w_wr_force;
  logic        w_wr_tlo;
  logic        w_wr_thi;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic [7:0]  w_rdata;
  logic [15:0] w_count;
  logic        w_expire;

  // --------------------------------------------------------------------------
  // Ready: combinational so the very first cs cycle already stalls the CPU.
  // Reset forces it high so an aborted access cannot hang the bus.
  // --------------------------------------------------------------------------
  always_comb begin
    ready = reset | ~cs | LP_NO_WAIT | (r_state == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // Wait-state FSM. The IDLE cycle in which cs first appears is itself a
  // ready-low cycle, so WAIT is left when the counter steps down to 1; this
  // gives exactly WAIT_STATES low cycles per access.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cs && !LP_NO_WAIT) begin
            r_wcnt <= LP_WS;
            if (WAIT_STATES == 1) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!cs) begin
            r_state <= ST_IDLE;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
            if (r_wcnt == 2'd2) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!cs || phase3) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_commit    = cs & write & ready & phase3;
  assign w_read      = cs & ~write;
  assign w_wr_force  = w_commit & (addr == ADDR_FORCE);
  assign w_wr_tlo    = w_commit & (addr == ADDR_TLO);
  assign w_wr_thi    = w_commit & (addr == ADDR_THI);
  assign w_wr_ctrl   = w_commit & (addr == ADDR_CTRL);
  assign w_wr_status = w_commit & (addr == ADDR_STATUS);

  always_comb begin
    w_rdata = 8'h00;
    case (addr)
      ADDR_FORCE:  w_rdata = {6'd0, r_force};
      ADDR_TLO:    w_rdata = w_count[7:0];
      ADDR_THI:    w_rdata = w_count[15:8];
      ADDR_CTRL:   w_rdata = {5'd0, r_ctrl};
      ADDR_STATUS: w_rdata = {7'd0, r_expired};
      default:     w_rdata = 8'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // Timer
  // --------------------------------------------------------------------------
  io_irq_timer #(
    .TIMER_RELOAD (TIMER_RELOAD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_run    (r_ctrl[CTRL_RUN]),
    .i_lo_we  (w_wr_tlo),
    .i_hi_we  (w_wr_thi),
    .i_wdata  (data_i),
    .o_count  (w_count),
    .o_expire (w_expire)
  );

  // --------------------------------------------------------------------------
  // Registers, read data and interrupt outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_force   <= 2'd0;
      r_ctrl    <= 3'd0;
      r_expired <= 1'b0;
      r_data_o  <= 8'h00;
      r_irq     <= 1'b0;
      r_nmi     <= 1'b0;
    end else begin
      if (w_wr_force) begin
        r_force <= data_i[1:0];
      end

      // A one-shot expiry stops the timer; a CPU write to CTRL in the same
      // cycle is the later, explicit intent and overrides it.
      if (w_wr_ctrl) begin
        r_ctrl <= data_i[2:0];
      end else if (w_expire && !r_ctrl[CTRL_AUTO]) begin
        r_ctrl[CTRL_RUN] <= 1'b0;
      end

      // Expiry beats a simultaneous write-1-to-clear so no event is lost.
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (w_wr_status && data_i[STATUS_EXP]) begin
        r_expired <= 1'b0;
      end

      if (w_read) begin
        r_data_o <= w_rdata;
      end

      r_irq <= r_force[FORCE_IRQ] | (r_expired & r_ctrl[CTRL_IEN]);
      r_nmi <= r_force[FORCE_NMI];
    end
  end

  assign data_o = r_data_o;
  assign irq    = r_irq;
  assign nmi    = r_nmi;

endmodule

// File: tb/tb_io_irq_ctrl.sv
module tb_io_irq_ctrl;

  localparam int WS = 2;

  logic       clk;
  logic       reset;
  logic       cs;
  logic [3:0] addr;
  logic       write;
  logic       phase3;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       ready;
  logic       irq;
  logic       nmi;

  int n_tests;
  int n_fail;

  io_irq_ctrl #(
    .WAIT_STATES  (WS),
    .TIMER_RELOAD (16'hFFFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cs     (cs),
    .addr   (addr),
    .write  (write),
    .phase3 (phase3),
    .data_i (data_i),
    .data_o (data_o),
    .ready  (ready),
    .irq    (irq),
    .nmi    (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: architectural view of the block
  logic [15:0] m_cnt;
  logic [15:0] m_rl;
  logic        m_run, m_auto, m_ien;
  logic        m_exp;
  logic [1:0]  m_force;
  logic [7:0]  m_do;
  logic        m_irq, m_nmi;
  int          m_acc;      // cs cycles spent in the current access
  logic        last_rdy;   // model ready of the last cycle
  logic        dut_rdy;    // DUT ready sampled in the last cycle

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 16'd0; m_rl = 16'hFFFF;
    m_run = 0; m_auto = 0; m_ien = 0; m_exp = 0;
    m_force = 2'd0; m_do = 8'h00; m_irq = 0; m_nmi = 0; m_acc = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return {6'd0, m_force};
      4'd1:    return m_cnt[7:0];
      4'd2:    return m_cnt[15:8];
      4'd3:    return {5'd0, m_ien, m_auto, m_run};
      4'd4:    return {7'd0, m_exp};
      default: return 8'h00;
    endcase
  endfunction

  // One rising edge of the architectural behaviour
  task automatic model_edge(input logic c, w, p, input logic [3:0] a, input logic [7:0] d,
                            input logic rdy);
    logic        commit, expire;
    logic [15:0] n_cnt, n_rl;
    logic        n_run, n_exp;
    logic [1:0]  n_force;
    commit  = c & w & rdy & p;
    expire  = 1'b0;
    n_cnt   = m_cnt;
    n_rl    = m_rl;
    n_run   = m_run;
    n_force = m_force;
    if (commit && a == 4'd1) n_rl[7:0] = d;
    if (commit && a == 4'd2) begin
      n_rl[15:8] = d;
      n_cnt = {d, m_rl[7:0]};
    end else if (m_run) begin
      if (m_cnt == 16'd0) n_cnt = m_rl;
      else begin
        n_cnt = m_cnt - 16'd1;
        expire = (m_cnt == 16'd1);
      end
    end
    if (expire && !m_auto) n_run = 1'b0;
    n_exp = expire ? 1'b1 : ((commit && a == 4'd4 && d[0]) ? 1'b0 : m_exp);
    if (commit && a == 4'd0) n_force = d[1:0];
    if (c && !w) m_do = model_read(a);
    m_irq = m_force[0] | (m_exp & m_ien);
    m_nmi = m_force[1];
    if (commit && a == 4'd3) begin
      n_run = d[0]; m_auto = d[1]; m_ien = d[2];
    end
    m_cnt = n_cnt; m_rl = n_rl; m_run = n_run; m_exp = n_exp; m_force = n_force;
    if (!c || (rdy && p)) m_acc = 0;
    else if (m_acc < 3) m_acc++;
  endtask

  // One bus cycle; entered shortly after a rising edge
  task automatic cyc(input logic c, w, p, input logic [3:0] a, input logic [7:0] d);
    logic exp_rdy;
    cs = c; write = w; phase3 = p; addr = a; data_i = d;
    #1;
    exp_rdy = !c || (m_acc >= WS);
    dut_rdy = ready;
    check("ready", {15'd0, ready}, {15'd0, exp_rdy});
    @(posedge clk);
    model_edge(c, w, p, a, d, exp_rdy);
    last_rdy = exp_rdy;
    #1;
    check("data_o", {8'd0, data_o}, {8'd0, m_do});
    check("irq", {15'd0, irq}, {15'd0, m_irq});
    check("nmi", {15'd0, nmi}, {15'd0, m_nmi});
  endtask

  task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d, input logic p);
    int k;
    k = 0;
    do begin
      cyc(1'b1, w, p, a, d);
      k++;
    end while (!last_rdy && k < 8);
    if (!last_rdy) check("access_timeout", 16'd0, 16'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_ready", {15'd0, ready}, 16'd1);
    check("rst_data_o", {8'd0, data_o}, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_nmi", {15'd0, nmi}, 16'd0);
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; phase3 = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int lows;
    int r;
    logic [3:0] ra;
    logic [7:0] rd;
    n_tests = 0; n_fail = 0;
    cs = 0; write = 0; phase3 = 0; addr = 0; data_i = 0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_ready", {15'd0, ready}, 16'd1);
    check("reset_irq", {15'd0, irq}, 16'd0);
    reset = 1'b0;
    idle(2);

    // FORCE irq/nmi on, then off
    access(1'b1, 4'd0, 8'h03, 1'b1);
    idle(1);
    check("force_irq", {15'd0, irq}, 16'd1);
    check("force_nmi", {15'd0, nmi}, 16'd1);
    access(1'b1, 4'd0, 8'h00, 1'b1);
    idle(1);
    check("unforce_irq", {15'd0, irq}, 16'd0);
    check("unforce_nmi", {15'd0, nmi}, 16'd0);

    // Wait-state read of CTRL
    access(1'b1, 4'd3, 8'h04, 1'b1);
    idle(1);
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
      if (!dut_rdy) lows++;
      if (last_rdy) break;
    end
    check("ws_low_cycles", 16'(lows), 16'd2);
    check("ws_read_ctrl", {8'd0, data_o}, 16'h0004);
    idle(1);

    // One-shot timer with reload 3
    access(1'b1, 4'd1, 8'h03, 1'b1);
    access(1'b1, 4'd2, 8'h00, 1'b1);
    access(1'b1, 4'd3, 8'h05, 1'b1);
    idle(3);
    access(1'b0, 4'd4, 8'h00, 1'b1);
    check("oneshot_expired", {8'd0, data_o}, 16'h0001);
    check("oneshot_irq", {15'd0, irq}, 16'd1);
    access(1'b0, 4'd3, 8'h00, 1'b1);
    check("oneshot_run_clr", {8'd0, data_o}, 16'h0004);
    access(1'b0, 4'd1, 8'h00, 1'b1);
    check("oneshot_cnt_lo", {8'd0, data_o}, 16'h0000);

    // Auto-reload, STATUS clear landing on the expiry edge
    access(1'b1, 4'd4, 8'h01, 1'b1);
    access(1'b1, 4'd2, 8'h00, 1'b1);
    access(1'b1, 4'd3, 8'h07, 1'b1);
    access(1'b1, 4'd4, 8'h01, 1'b1);
    access(1'b0, 4'd4, 8'h00, 1'b1);
    check("clr_vs_expiry", {8'd0, data_o}, 16'h0001);
    for (int i = 0; i < 6; i++) access(1'b0, 4'd1, 8'h00, 1'b1);
    access(1'b1, 4'd3, 8'h00, 1'b1);
    access(1'b1, 4'd4, 8'h01, 1'b1);
    idle(1);

    // No commit without phase3
    access(1'b1, 4'd0, 8'h03, 1'b0);
    idle(2);
    check("nophase3_nmi", {15'd0, nmi}, 16'd0);

    // Reset in the middle of a wait-stated access
    access(1'b1, 4'd0, 8'h03, 1'b1);
    idle(1);
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 8'h07);
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 8'h07);
    pulse_reset();
    idle(2);
    check("post_rst_nmi", {15'd0, nmi}, 16'd0);
    access(1'b1, 4'd2, 8'h00, 1'b1);
    access(1'b0, 4'd1, 8'h00, 1'b1);
    check("post_rst_latch_lo", {8'd0, data_o}, 16'h00FF);
    access(1'b0, 4'd3, 8'h00, 1'b1);
    check("post_rst_ctrl", {8'd0, data_o}, 16'h0000);
    idle(1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 19));
      ra = 4'($urandom_range(0, 15));
      if (ra > 4'd6 && $urandom_range(0, 3) != 0) ra = 4'($urandom_range(0, 4));
      rd = 8'($urandom);
      if (ra == 4'd2) rd = 8'($urandom_range(0, 1));
      if (ra == 4'd1) rd = 8'($urandom_range(0, 7));
      if (r < 3) idle(1);
      else if (r == 19 && i % 5 == 0) pulse_reset();
      else access(1'($urandom_range(0, 1)), ra, rd, ($urandom_range(0, 7) != 0));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
